// File: rtl/irq_claim_ctrl.sv
// Core-side interrupt claim controller: decides preemption against a nested
// priority-level stack, offers the winner to the core and pulses the claim ack.
module irq_claim_ctrl #(
   parameter  int NrIrqLines = 64,
   parameter  int NrIrqPrios = 32,
   parameter  int NestDepth  = 4,
   localparam int IrqWidth   = $clog2(NrIrqLines),
   localparam int PrioWidth  = $clog2(NrIrqPrios),
   localparam int DepthWidth = $clog2(NestDepth + 1)
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  irq_valid_i,
   input  logic [IrqWidth-1:0]   irq_id_i,
   input  logic [PrioWidth-1:0]  irq_level_i,
   input  logic                  irq_heti_i,
   input  logic                  irq_nest_i,
   output logic                  irq_ack_o,
   output logic [IrqWidth-1:0]   irq_id_o,
   input  logic                  mie_i,
   output logic                  core_irq_req_o,
   output logic [IrqWidth-1:0]   core_irq_id_o,
   output logic                  core_irq_heti_o,
   input  logic                  core_irq_take_i,
   input  logic                  core_mret_i,
   output logic [PrioWidth-1:0]  cur_level_o,
   output logic [DepthWidth-1:0] depth_o
);

   typedef enum logic [1:0] {IDLE, OFFER, ACK} state_e;

   state_e                state_q;
   logic [IrqWidth-1:0]   offer_id_q;
   logic [PrioWidth-1:0]  offer_lvl_q;
   logic                  offer_heti_q;
   logic                  offer_nest_q;
   logic                  req_q;
   logic                  ack_q;
   logic [IrqWidth-1:0]   ack_id_q;

   logic [PrioWidth-1:0]  stk_lvl_q  [NestDepth];
   logic [PrioWidth-1:0]  stk_lvl_d  [NestDepth];
   logic                  stk_nest_q [NestDepth];
   logic                  stk_nest_d [NestDepth];
   logic [DepthWidth-1:0] depth_q, depth_d, wr_idx;

   logic [PrioWidth-1:0]  top_lvl;
   logic                  top_nest;
   logic                  eligible, do_pop, do_push;

   // An empty stack behaves as level 0 with nesting allowed.
   always_comb begin
      top_lvl  = '0;
      top_nest = 1'b1;
      for (int i = 0; i < NestDepth; i++) begin
         if (depth_q == DepthWidth'(i + 1)) begin
            top_lvl  = stk_lvl_q[i];
            top_nest = stk_nest_q[i];
         end
      end
   end

   assign eligible = irq_valid_i && mie_i && (irq_level_i > top_lvl) &&
                     (depth_q < DepthWidth'(NestDepth)) && top_nest;
   assign do_pop   = core_mret_i && (depth_q != '0);
   assign do_push  = (state_q == OFFER) && core_irq_take_i;

   // Pop happens before push, so a simultaneous mret and take replaces the top.
   always_comb begin
      stk_lvl_d  = stk_lvl_q;
      stk_nest_d = stk_nest_q;
      wr_idx     = do_pop ? depth_q - 1'b1 : depth_q;
      depth_d    = wr_idx;
      if (do_push) begin
         for (int i = 0; i < NestDepth; i++) begin
            if (wr_idx == DepthWidth'(i)) begin
               stk_lvl_d[i]  = offer_lvl_q;
               stk_nest_d[i] = offer_nest_q;
            end
         end
         depth_d = wr_idx + 1'b1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         depth_q <= '0;
         for (int i = 0; i < NestDepth; i++) begin
            stk_lvl_q[i]  <= '0;
            stk_nest_q[i] <= 1'b0;
         end
      end else begin
         depth_q    <= depth_d;
         stk_lvl_q  <= stk_lvl_d;
         stk_nest_q <= stk_nest_d;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q      <= IDLE;
         offer_id_q   <= '0;
         offer_lvl_q  <= '0;
         offer_heti_q <= 1'b0;
         offer_nest_q <= 1'b0;
         req_q        <= 1'b0;
         ack_q        <= 1'b0;
         ack_id_q     <= '0;
      end else begin
         ack_q    <= 1'b0;
         ack_id_q <= '0;
         case (state_q)
            IDLE: begin
               if (eligible) begin
                  offer_id_q   <= irq_id_i;
                  offer_lvl_q  <= irq_level_i;
                  offer_heti_q <= irq_heti_i;
                  offer_nest_q <= irq_nest_i;
                  req_q        <= 1'b1;
                  state_q      <= OFFER;
               end
            end
            OFFER: begin
               if (core_irq_take_i) begin
                  req_q    <= 1'b0;
                  ack_q    <= 1'b1;
                  ack_id_q <= offer_id_q;
                  state_q  <= ACK;
               end else if (!eligible || (irq_id_i != offer_id_q)) begin
                  req_q   <= 1'b0;
                  state_q <= IDLE;
               end
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign irq_ack_o       = ack_q;
   assign irq_id_o        = ack_id_q;
   assign core_irq_req_o  = req_q;
   assign core_irq_id_o   = offer_id_q;
   assign core_irq_heti_o = offer_heti_q;
   assign cur_level_o     = top_lvl;
   assign depth_o         = depth_q;

endmodule
